// File: rtl/trap_sequencer_if.sv
// Handshake bundle between the main control FSM (master) and the trap sequencer (slave).
interface trap_sequencer_if #(
  parameter int NUM_IRQ = 8,
  parameter int XLEN    = 32
);
  logic [NUM_IRQ-1:0] irq;
  logic [NUM_IRQ-1:0] irq_en;
  logic               mie;
  logic               boundary;
  logic               exc_req;
  logic [3:0]         exc_code;
  logic               mret;
  logic [XLEN-1:0]    pc;
  logic [XLEN-1:0]    mtvec;
  logic [XLEN-1:0]    mepc;
  logic               trap_take;
  logic               busy;
  logic               csr_we;
  logic [11:0]        csr_addr;
  logic [XLEN-1:0]    csr_wdata;
  logic               pc_load;
  logic [XLEN-1:0]    pc_next;
  logic               mie_set;
  logic               mie_reset;
  logic [NUM_IRQ-1:0] pending;

  modport master (
    output irq, irq_en, mie, boundary, exc_req, exc_code, mret, pc, mtvec, mepc,
    input  trap_take, busy, csr_we, csr_addr, csr_wdata, pc_load, pc_next,
           mie_set, mie_reset, pending
  );

  modport slave (
    input  irq, irq_en, mie, boundary, exc_req, exc_code, mret, pc, mtvec, mepc,
    output trap_take, busy, csr_we, csr_addr, csr_wdata, pc_load, pc_next,
           mie_set, mie_reset, pending
  );
endinterface

// File: rtl/trap_sequencer.sv
// Trap entry/return sequencer: saves mepc/mcause, then vectors the PC; handles mret.
// Optional macro TRAP_VECTORED_EN: interrupts vector to base + 4*cause_code.
module trap_sequencer #(
  parameter int                 NUM_IRQ  = 8,
  parameter int                 XLEN     = 32,
  parameter int                 IRQ_BASE = 16,
  parameter logic [NUM_IRQ-1:0] IRQ_EDGE = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  trap_sequencer_if.slave   bus
);

  localparam int SEL_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
  localparam logic [XLEN-1:0] INT_BIT = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SAVE_EPC, SAVE_CAUSE, VECTOR} state_t;

  state_t             state_q, state_d;
  logic [XLEN-1:0]    cause_q, cause_d;
  logic [NUM_IRQ-1:0] pend;
  logic [NUM_IRQ-1:0] active;
  logic               irq_hit;
  logic [SEL_W-1:0]   irq_sel;
  logic               int_take;
  logic [XLEN-1:0]    base;
  logic [XLEN-1:0]    vec_pc;

  logic               trap_take;
  logic               csr_we;
  logic [11:0]        csr_addr;
  logic [XLEN-1:0]    csr_wdata;
  logic               pc_load;
  logic [XLEN-1:0]    pc_next;
  logic               mie_set;
  logic               mie_reset;

  // Per-channel pending: level channels are transparent, edge channels latch a rising edge.
  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_ch
    if (IRQ_EDGE[g]) begin : g_edge
      logic irq_q;
      logic pend_q;
      logic clr;
      assign clr = int_take && (irq_sel == SEL_W'(g));
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          irq_q  <= 1'b0;
          pend_q <= 1'b0;
        end else begin
          irq_q  <= bus.irq[g];
          pend_q <= (pend_q & ~clr) | (bus.irq[g] & ~irq_q);
        end
      end
      assign pend[g] = pend_q;
    end else begin : g_lvl
      assign pend[g] = bus.irq[g];
    end
  end

  assign active = pend & bus.irq_en;

  always_comb begin
    irq_hit = 1'b0;
    irq_sel = '0;
    for (int i = NUM_IRQ-1; i >= 0; i--) begin
      if (active[i]) begin
        irq_hit = 1'b1;
        irq_sel = SEL_W'(i);
      end
    end
  end

  assign base = bus.mtvec & ~XLEN'(3);
`ifdef TRAP_VECTORED_EN
  assign vec_pc = cause_q[XLEN-1] ? base + {cause_q[XLEN-3:0], 2'b00} : base;
`else
  assign vec_pc = base;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    trap_take = 1'b0;
    int_take  = 1'b0;
    csr_we    = 1'b0;
    csr_addr  = '0;
    csr_wdata = '0;
    pc_load   = 1'b0;
    pc_next   = '0;
    mie_set   = 1'b0;
    mie_reset = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Gated by reset_n so that reset silences the combinational IDLE outputs too.
        if (reset_n) begin
          if (bus.exc_req) begin
            trap_take = 1'b1;
            cause_d   = XLEN'(bus.exc_code);
            state_d   = SAVE_EPC;
          end else if (bus.boundary && bus.mie && irq_hit) begin
            trap_take = 1'b1;
            int_take  = 1'b1;
            cause_d   = INT_BIT | (XLEN'(IRQ_BASE) + XLEN'(irq_sel));
            state_d   = SAVE_EPC;
          end else if (bus.mret) begin
            pc_load = 1'b1;
            pc_next = bus.mepc;
            mie_set = 1'b1;
          end
        end
      end
      SAVE_EPC: begin
        csr_we    = 1'b1;
        csr_addr  = 12'h341;
        csr_wdata = bus.pc;
        mie_reset = 1'b1;
        state_d   = SAVE_CAUSE;
      end
      SAVE_CAUSE: begin
        csr_we    = 1'b1;
        csr_addr  = 12'h342;
        csr_wdata = cause_q;
        state_d   = VECTOR;
      end
      VECTOR: begin
        pc_load = 1'b1;
        pc_next = vec_pc;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.trap_take = trap_take;
  assign bus.busy      = (state_q != IDLE);
  assign bus.csr_we    = csr_we;
  assign bus.csr_addr  = csr_addr;
  assign bus.csr_wdata = csr_wdata;
  assign bus.pc_load   = pc_load;
  assign bus.pc_next   = pc_next;
  assign bus.mie_set   = mie_set;
  assign bus.mie_reset = mie_reset;
  assign bus.pending   = pend;

endmodule

// File: tb/tb_trap_sequencer.sv
// Randomised scoreboard bench for trap_sequencer; channel 0 is edge-triggered.
module tb_trap_sequencer;

  logic clk;
  logic reset_n;

  trap_sequencer_if #(.NUM_IRQ(8), .XLEN(32)) bif ();

  trap_sequencer #(
    .NUM_IRQ (8),
    .XLEN    (32),
    .IRQ_BASE(16),
    .IRQ_EDGE(8'h01)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic        ld;
    logic [11:0] addr;
    logic [31:0] data;
    logic        ms;
    logic        mr;
    logic [7:0]  off;
  } ev_t;

  ev_t expq[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  take_cyc = 0;
  bit  ep = 1'b0;
  bit  prev0 = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic ev_t mk(input logic we, input logic ld, input logic [11:0] a,
                             input logic [31:0] d, input logic ms, input logic mr,
                             input logic [7:0] off);
    ev_t e;
    e = '{we:we, ld:ld, addr:a, data:d, ms:ms, mr:mr, off:off};
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every CSR write or PC load must match the next expected event.
  always @(negedge clk) begin : mon
    ev_t o;
    ev_t e;
    if (bif.trap_take) take_cyc = cyc;
    if (bif.csr_we || bif.pc_load) begin
      o = mk(bif.csr_we, bif.pc_load, bif.csr_addr,
             bif.csr_we ? bif.csr_wdata : bif.pc_next,
             bif.mie_set, bif.mie_reset, 8'(cyc - take_cyc));
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got %0h expected none", o);
      end else begin
        e = expq.pop_front();
        if (e.off == 8'hFF) o.off = 8'hFF;
        if (o !== e) begin
          errors++;
          $display("FAIL event: got %0h expected %0h", o, e);
        end
      end
    end
  end

  // Push the three-step entry sequence for a trap taken this cycle.
  task automatic push_trap(input logic [31:0] pc_v, input logic [31:0] cause,
                           input logic [31:0] vec);
    expq.push_back(mk(1'b1, 1'b0, 12'h341, pc_v, 1'b0, 1'b1, 8'd1));
    expq.push_back(mk(1'b1, 1'b0, 12'h342, cause, 1'b0, 1'b0, 8'd2));
    expq.push_back(mk(1'b0, 1'b1, 12'h000, vec, 1'b0, 1'b0, 8'd3));
  endtask

  // One transaction: a quiet setup cycle (captures edges), then a decision cycle.
  task automatic txn(input logic [7:0] irq_v, input logic [7:0] en_v, input bit mie_v,
                     input bit bnd_v, input bit exc_v, input logic [3:0] code_v,
                     input bit mret_req, input logic [31:0] pc_v,
                     input logic [31:0] tv_v, input logic [31:0] mepc_v);
    logic [7:0]  pend, act, lsb;
    logic [31:0] base, cause, vec;
    int          w;
    bit          take, mret_v;
    @(posedge clk); #1;
    bif.irq = irq_v; bif.irq_en = en_v; bif.pc = pc_v; bif.mtvec = tv_v; bif.mepc = mepc_v;
    bif.mie = 1'b0; bif.boundary = 1'b0; bif.exc_req = 1'b0; bif.mret = 1'b0;
    @(posedge clk); #1;
    if (!prev0 && irq_v[0]) ep = 1'b1;
    prev0  = irq_v[0];
    pend   = {irq_v[7:1], ep};
    act    = pend & en_v;
    take   = exc_v || (mie_v && bnd_v && act != 0);
    mret_v = mret_req && !take;
    lsb    = act & (~act + 8'd1);
    w      = $clog2(lsb);
    base   = tv_v & 32'hFFFF_FFFC;
    bif.mie = mie_v; bif.boundary = bnd_v; bif.exc_req = exc_v;
    bif.exc_code = code_v; bif.mret = mret_v;
    if (take) begin
      if (exc_v) begin
        cause = {28'd0, code_v};
        vec   = base;
      end else begin
        cause = 32'h8000_0000 | 32'(16 + w);
        vec   = base;
`ifdef TRAP_VECTORED_EN
        vec   = base + 32'(4 * (16 + w));
`endif
        if (w == 0) ep = 1'b0;
      end
      push_trap(pc_v, cause, vec);
    end else if (mret_v) begin
      expq.push_back(mk(1'b0, 1'b1, 12'h000, mepc_v, 1'b1, 1'b0, 8'hFF));
    end
    @(negedge clk);
    chk("trap_take", bif.trap_take, take);
    chk("pending", bif.pending, pend);
    @(posedge clk); #1;
    bif.mie = 1'b0; bif.boundary = 1'b0; bif.exc_req = 1'b0; bif.mret = 1'b0;
    if (take) begin
      repeat (3) @(posedge clk);
      #1;
    end
    chk("busy_done", bif.busy, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0;
    bif.irq = 8'h0B; bif.irq_en = 8'hFF; bif.mie = 1'b1; bif.boundary = 1'b1;
    bif.exc_req = 1'b1; bif.exc_code = 4'd3; bif.mret = 1'b1;
    bif.pc = 32'h2000; bif.mtvec = 32'h100; bif.mepc = 32'h0;
    #2;
    chk("reset_outs", {bif.trap_take, bif.busy, bif.csr_we, bif.pc_load, bif.mie_set,
                       bif.mie_reset, bif.csr_addr, bif.csr_wdata, bif.pc_next}, '0);
    chk("reset_pending", bif.pending, 8'h0A);
    bif.irq = 8'h00; bif.exc_req = 1'b0; bif.mret = 1'b0; bif.mie = 1'b0; bif.boundary = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Level interrupt on channel 3, then two simultaneous requests.
    txn(8'h08, 8'hFF, 1, 1, 0, 4'd0, 0, 32'h2000, 32'h100, 32'h0);
    txn(8'h22, 8'hFF, 1, 1, 0, 4'd0, 0, 32'h2000, 32'h100, 32'h0);

    // Edge channel: pulse while masked, pending holds, trap clears it.
    @(posedge clk); #1;
    bif.irq = 8'h01; bif.irq_en = 8'hFF; bif.pc = 32'h2000; bif.mtvec = 32'h100;
    @(posedge clk); #1;
    bif.irq = 8'h00;
    @(negedge clk); chk("edge_set", bif.pending, 8'h01);
    @(posedge clk); #1;
    @(negedge clk); chk("edge_held", bif.pending, 8'h01);
    @(posedge clk); #1;
    bif.mie = 1'b1; bif.boundary = 1'b1;
`ifdef TRAP_VECTORED_EN
    push_trap(32'h2000, 32'h8000_0010, 32'h140);
`else
    push_trap(32'h2000, 32'h8000_0010, 32'h100);
`endif
    @(negedge clk); chk("edge_take", bif.trap_take, 1'b1);
    @(posedge clk); #1;
    bif.mie = 1'b0; bif.boundary = 1'b0;
    @(negedge clk); chk("edge_clr", bif.pending, 8'h00);
    repeat (3) @(posedge clk);
    #1 chk("edge_busy", bif.busy, 1'b0);
    ep = 1'b0; prev0 = 1'b0;

    // Exception beats a pending interrupt.
    txn(8'h01, 8'hFF, 1, 1, 1, 4'd2, 0, 32'h2000, 32'h100, 32'h0);

    // Reset in SAVE_CAUSE abandons the sequence.
    @(posedge clk); #1;
    bif.irq = 8'h08; bif.irq_en = 8'h08; bif.pc = 32'h2000;
    @(posedge clk); #1;
    bif.mie = 1'b1; bif.boundary = 1'b1;
    expq.push_back(mk(1'b1, 1'b0, 12'h341, 32'h2000, 1'b0, 1'b1, 8'd1));
    @(negedge clk); chk("rst_take", bif.trap_take, 1'b1);
    @(posedge clk); #1;
    bif.mie = 1'b0; bif.boundary = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0; bif.exc_req = 1'b1; bif.mret = 1'b1;
    #1;
    chk("rst_mid_outs", {bif.trap_take, bif.busy, bif.csr_we, bif.pc_load, bif.mie_set,
                         bif.mie_reset, bif.csr_addr, bif.csr_wdata, bif.pc_next}, '0);
    chk("rst_mid_pending", bif.pending, 8'h08);
    @(posedge clk); #1;
    bif.exc_req = 1'b0; bif.mret = 1'b0; reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1 chk("rst_busy", bif.busy, 1'b0);
    bif.irq = 8'h00; ep = 1'b0; prev0 = 1'b0;

    // mret from IDLE.
    txn(8'h00, 8'h00, 0, 0, 0, 4'd0, 1, 32'h2000, 32'h100, 32'h2004);

    for (int n = 0; n < 80; n++) begin
      txn(8'($urandom), 8'($urandom), ($urandom % 4) != 0, ($urandom % 4) != 0,
          ($urandom % 5) == 0, 4'($urandom), ($urandom % 3) == 0,
          $urandom, $urandom, $urandom);
    end

    repeat (4) @(posedge clk);
    #1 chk("queue_empty", 128'(expq.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
